// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the little 8-bit CPU: control FSM state encoding,
// instruction field positions, opcode values and the ALU operation codes
// the controller drives. The ALU and assembler tests import this too.
// There are no ports; it is a package.
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    RESET_S = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    HALT    = 3'd6
  } state_t;

  // Instruction byte layout: opcode[7:4], rd[3:2], rs[1:0]
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_NOT   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_LOAD  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_BEQZ  = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // BEQZ tests R[rd]==0 by OR-ing the register with itself
  localparam logic [2:0] ALU_OR = 3'd3;

endpackage

// File: rtl/instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder
// Purely combinational decode of the latched instruction register into the
// ALU operation, one-hot class flags and the register fields.
// Ports:
//   i_ir       in  8  latched instruction byte
//   o_aluOp    out 3  ALU op (opcode[2:0] for ALU ops, OR for BEQZ, else 0)
//   o_isAlu    out 1  opcode 0..5
//   o_isLoad   out 1  opcode 6
//   o_isStore  out 1  opcode 7
//   o_isBeqz   out 1  opcode 8
//   o_isJmp    out 1  opcode 9
//   o_isHalt   out 1  opcode 15 (10..14 leave every flag low: NOP)
//   o_rd       out 2  rd field
//   o_rs       out 2  rs field
// ---------------------------------------------------------------------------
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] i_ir,
  output logic [2:0] o_aluOp,
  output logic       o_isAlu,
  output logic       o_isLoad,
  output logic       o_isStore,
  output logic       o_isBeqz,
  output logic       o_isJmp,
  output logic       o_isHalt,
  output logic [1:0] o_rd,
  output logic [1:0] o_rs
);

  logic [3:0] w_opcode;

  assign w_opcode = i_ir[OPC_MSB:OPC_LSB];
  assign o_rd     = i_ir[RD_MSB:RD_LSB];
  assign o_rs     = i_ir[RS_MSB:RS_LSB];

  // Classify the opcode. Everything defaults low so the reserved opcodes
  // 10..14 fall out as NOPs with no class flag set and a zero ALU op.
  always_comb begin
    o_aluOp   = 3'd0;
    o_isAlu   = 1'b0;
    o_isLoad  = 1'b0;
    o_isStore = 1'b0;
    o_isBeqz  = 1'b0;
    o_isJmp   = 1'b0;
    o_isHalt  = 1'b0;
    case (w_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_SLT: begin
        o_isAlu = 1'b1;
        o_aluOp = w_opcode[2:0];
      end
      OP_LOAD:  o_isLoad  = 1'b1;
      OP_STORE: o_isStore = 1'b1;
      OP_BEQZ: begin
        o_isBeqz = 1'b1;
        o_aluOp  = ALU_OR;
      end
      OP_JMP:   o_isJmp   = 1'b1;
      OP_HALT:  o_isHalt  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
// Multi-cycle control unit: fetch, decode, execute, optional memory access
// and register write-back, plus a terminal HALT state.
// Ports:
//   clk        in  1  system clock, rising edge
//   rst_n      in  1  synchronous active-low reset
//   imem_req   out 1  instruction fetch request (FETCH only)
//   imem_addr  out 8  fetch address, equals pc
//   imem_ack   in  1  fetch complete
//   imem_data  in  8  instruction byte, valid with imem_ack
//   dmem_req   out 1  data access request (MEM only)
//   dmem_we    out 1  1 = store
//   dmem_ack   in  1  data access complete
//   rf_ra      out 2  register read address A (rd)
//   rf_rb      out 2  register read address B (rs, or rd for BEQZ execute)
//   rf_we      out 1  register write enable (WB only)
//   rf_wa      out 2  register write address
//   wb_sel     out 1  0 = ALU result, 1 = dmem read data
//   alu_op     out 3  ALU operation code
//   alu_zero   in  1  ALU zero flag
//   rs_data    in  8  register value of rs, jump target
//   pc         out 8  program counter
//   halted     out 1  high in HALT
// ---------------------------------------------------------------------------
module cpu_control_fsm
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic [1:0] rf_ra,
  output logic [1:0] rf_rb,
  output logic       rf_we,
  output logic [1:0] rf_wa,
  output logic       wb_sel,
  output logic [2:0] alu_op,
  input  logic       alu_zero,
  input  logic [7:0] rs_data,
  output logic [7:0] pc,
  output logic       halted
);

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;

  state_t     w_stateNext;
  logic [7:0] w_pcNext;
  logic [7:0] w_irNext;

  logic [2:0] w_aluOp;
  logic       w_isAlu;
  logic       w_isLoad;
  logic       w_isStore;
  logic       w_isBeqz;
  logic       w_isJmp;
  logic       w_isHalt;
  logic [1:0] w_rd;
  logic [1:0] w_rs;

  instr_decoder u_decoder (
    .i_ir      (r_ir),
    .o_aluOp   (w_aluOp),
    .o_isAlu   (w_isAlu),
    .o_isLoad  (w_isLoad),
    .o_isStore (w_isStore),
    .o_isBeqz  (w_isBeqz),
    .o_isJmp   (w_isJmp),
    .o_isHalt  (w_isHalt),
    .o_rd      (w_rd),
    .o_rs      (w_rs)
  );

  // State, program counter and instruction register. Reset is sampled on
  // the clock edge, so an in-flight fetch or data access is simply dropped
  // and any ack arriving afterwards lands in RESET_S where nobody looks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RESET_S;
      r_pc    <= 8'd0;
      r_ir    <= 8'd0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      r_ir    <= w_irNext;
    end
  end

  // Next-state logic together with pc/ir updates. Acks are only looked at
  // in the state that issues the matching request, which is what makes
  // stray acks harmless everywhere else. The pc increment wraps naturally
  // in 8 bits, and a jump to the current pc needs no special handling.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_irNext    = r_ir;
    case (r_state)
      RESET_S: w_stateNext = FETCH;
      FETCH: begin
        if (imem_ack) begin
          w_irNext    = imem_data;
          w_pcNext    = r_pc + 8'd1;
          w_stateNext = DECODE;
        end
      end
      DECODE: w_stateNext = EXECUTE;
      EXECUTE: begin
        if (w_isAlu) begin
          w_stateNext = WB;
        end else if (w_isLoad || w_isStore) begin
          w_stateNext = MEM;
        end else if (w_isBeqz) begin
          if (alu_zero) begin
            w_pcNext = rs_data;
          end
          w_stateNext = FETCH;
        end else if (w_isJmp) begin
          w_pcNext    = rs_data;
          w_stateNext = FETCH;
        end else if (w_isHalt) begin
          w_stateNext = HALT;
        end else begin
          w_stateNext = FETCH;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          w_stateNext = w_isLoad ? WB : FETCH;
        end
      end
      WB:      w_stateNext = FETCH;
      HALT:    w_stateNext = HALT;
      default: w_stateNext = RESET_S;
    endcase
  end

  // Moore-style outputs decoded from the current state. Because each
  // request is tied to exactly one state, imem_req, dmem_req and rf_we can
  // never be high together. alu_op follows the instruction register, so it
  // holds the decoded value for the whole DECODE..WB window; for BEQZ the
  // decoder already reports OR, and in EXECUTE both read ports point at rd
  // so the ALU sees rd | rd.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    rf_wa    = 2'd0;
    wb_sel   = 1'b0;
    halted   = 1'b0;
    rf_ra    = w_rd;
    rf_rb    = w_rs;
    alu_op   = w_aluOp;
    case (r_state)
      FETCH: imem_req = 1'b1;
      EXECUTE: begin
        if (w_isBeqz) begin
          rf_rb = w_rd;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_isStore;
      end
      WB: begin
        rf_we  = 1'b1;
        rf_wa  = w_rd;
        wb_sel = w_isLoad;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign pc        = r_pc;
  assign imem_addr = r_pc;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_control_fsm
// Directed bench for the CPU control FSM. Inputs change on the falling edge
// and outputs are sampled on the falling edge, so every observation reflects
// the state entered at the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_cpu_control_fsm;

  logic       clk;
  logic       rst_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;
  logic [1:0] rf_ra;
  logic [1:0] rf_rb;
  logic       rf_we;
  logic [1:0] rf_wa;
  logic       wb_sel;
  logic [2:0] alu_op;
  logic       alu_zero;
  logic [7:0] rs_data;
  logic [7:0] pc;
  logic       halted;

  int totalChecks = 0;
  int badChecks   = 0;

  cpu_control_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .rf_ra     (rf_ra),
    .rf_rb     (rf_rb),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .alu_zero  (alu_zero),
    .rs_data   (rs_data),
    .pc        (pc),
    .halted    (halted)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive all data-side inputs, then advance one full clock to the next
  // falling edge where outputs are sampled
  task automatic applyStimulus(input logic iAck, input logic [7:0] iData,
                               input logic dAck, input logic zero,
                               input logic [7:0] rsd);
    imem_ack  = iAck;
    imem_data = iData;
    dmem_ack  = dAck;
    alu_zero  = zero;
    rs_data   = rsd;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    dmem_ack  = 1'b0;
    alu_zero  = 1'b0;
    rs_data   = 8'h00;
    @(negedge clk);

    // Reset state
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("rst_pc", 16'(pc), 16'h00);
    checkOutput("rst_reqs", 16'({imem_req, dmem_req, dmem_we, rf_we}), 16'h0);
    checkOutput("rst_misc", 16'({halted, wb_sel, rf_wa, alu_op}), 16'h0);

    // One cycle in RESET_S after release, then FETCH
    rst_n = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("fetch_req", 16'(imem_req), 16'h1);
    checkOutput("fetch_addr", 16'(imem_addr), 16'h00);

    // ADD rd=1 rs=2 (0x06), zero-wait fetch: WB on 4th cycle
    applyStimulus(1, 8'h06, 0, 0, 8'h00);
    checkOutput("add_dec_req", 16'(imem_req), 16'h0);
    checkOutput("add_dec_pc", 16'(pc), 16'h01);
    checkOutput("add_dec_ra", 16'(rf_ra), 16'h1);
    checkOutput("add_dec_rb", 16'(rf_rb), 16'h2);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("add_ex_we", 16'(rf_we), 16'h0);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("add_wb_we", 16'(rf_we), 16'h1);
    checkOutput("add_wb_wa", 16'(rf_wa), 16'h1);
    checkOutput("add_wb_op", 16'(alu_op), 16'h0);
    checkOutput("add_wb_sel", 16'(wb_sel), 16'h0);
    checkOutput("add_wb_pc", 16'(pc), 16'h01);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("add_next_we", 16'(rf_we), 16'h0);
    checkOutput("add_next_fetch", 16'({imem_req, imem_addr}), 16'h101);

    // SUB rd=2 rs=3 (0x1B)
    applyStimulus(1, 8'h1B, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("sub_wb", 16'({rf_we, rf_wa, alu_op}), 16'({1'b1, 2'd2, 3'd1}));
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("sub_next_pc", 16'(pc), 16'h02);

    // LOAD rd=3 rs=2 (0x6E), dmem_ack in the 4th request cycle; a stray
    // imem_ack during MEM must be ignored
    applyStimulus(1, 8'h6E, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("load_mem%0d", i),
                  16'({imem_req, dmem_req, dmem_we, rf_we}), 16'b0100);
      applyStimulus(i == 0, 8'hFF, i == 3, 0, 8'h00);
    end
    checkOutput("load_wb", 16'({rf_we, wb_sel, rf_wa, dmem_req}), 16'b11110);
    checkOutput("load_wb_pc", 16'(pc), 16'h03);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);

    // STORE rd=0 rs=1 (0x71), zero-wait: MEM then straight back to FETCH
    applyStimulus(1, 8'h71, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("store_mem", 16'({dmem_req, dmem_we}), 16'b11);
    applyStimulus(0, 8'h00, 1, 0, 8'h00);
    checkOutput("store_done", 16'({imem_req, dmem_req, rf_we, imem_addr}), 16'h404);

    // BEQZ rd=0 rs=1 (0x81) taken
    applyStimulus(1, 8'h81, 0, 0, 8'h00);
    checkOutput("beqz_dec_op", 16'(alu_op), 16'h3);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("beqz_ex_ports", 16'({alu_op, rf_ra, rf_rb}), 16'({3'd3, 2'd0, 2'd0}));
    applyStimulus(0, 8'h00, 0, 1, 8'h40);
    checkOutput("beqz_taken_pc", 16'({imem_req, pc}), 16'h140);

    // BEQZ not taken
    applyStimulus(1, 8'h81, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h40);
    checkOutput("beqz_fall_pc", 16'({imem_req, pc}), 16'h141);

    // JMP rs=0 (0x90) to 0xFF
    applyStimulus(1, 8'h90, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'hFF);
    checkOutput("jmp_pc", 16'({imem_req, imem_addr}), 16'h1FF);

    // NOP (0xA0) fetched at 0xFF wraps pc to 0x00, 3 cycles total
    applyStimulus(1, 8'hA0, 0, 0, 8'h00);
    checkOutput("wrap_pc", 16'(pc), 16'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("nop_done", 16'({imem_req, dmem_req, rf_we, pc}), 16'h400);

    // Reset in the middle of a stalled STORE, then a late dmem_ack
    applyStimulus(1, 8'h71, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("abort_mem_req", 16'(dmem_req), 16'h1);
    rst_n = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("abort_rst", 16'({imem_req, dmem_req, dmem_we, pc}), 16'h000);
    rst_n = 1'b1;
    applyStimulus(0, 8'h00, 1, 0, 8'h00);
    checkOutput("abort_fetch", 16'({imem_req, dmem_req, pc}), 16'h200);
    applyStimulus(0, 8'h00, 1, 0, 8'h00);
    checkOutput("abort_late_ack", 16'({imem_req, dmem_req, pc}), 16'h200);

    // HALT (0xF0): sticky, no requests, spurious acks ignored
    applyStimulus(1, 8'hF0, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("halt_c%0d", i),
                  16'({imem_req, dmem_req, rf_we, halted, pc}), 16'h101);
      applyStimulus(1, 8'h06, i[0], 0, 8'h55);
    end

    // Reset leaves HALT
    rst_n = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 8'h00);
    checkOutput("halt_rst", 16'({halted, pc}), 16'h000);
    rst_n = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
